// File: rtl/ac_lockin_detector.sv
// Lock-in detector: correlates a sampled voltage stream against an internal sine/cosine
// reference and reports in-phase, quadrature and DC sums over a programmed sample count.
module ac_lockin_detector #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int NSAMP_W = 16,
    parameter int ACC_W   = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [NSAMP_W-1:0] n_samples,
    input  logic [DATA_W-1:0]  offset,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic               busy,
    output logic               res_valid,
    output logic [ACC_W-1:0]   i_acc,
    output logic [ACC_W-1:0]   q_acc,
    output logic [ACC_W-1:0]   dc_acc
);
    localparam int DW = DATA_W + 1;
    localparam int PW = DATA_W + 17;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [PHASE_W-1:0]     phase, inc_r;
    logic [NSAMP_W-1:0]     count, n_r;
    logic [DATA_W-1:0]      off_r;
    logic [1:0]             drain_cnt;
    logic                   v0, v1, v2;
    logic [DATA_W-1:0]      x0;
    logic [5:0]             idx0;
    logic signed [DW-1:0]   diff1, d2;
    logic signed [15:0]     sin1, cos1;
    logic signed [PW-1:0]   pi2, pq2;
    logic                   accept;

    assign s_ready = (state == RUN);
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;

    // Quarter-wave table folded by symmetry: LUT[32-k] = LUT[k], LUT[k+32] = -LUT[k].
    function automatic logic signed [15:0] lut(input logic [5:0] k);
        logic [4:0]         j;
        logic [5:0]         t;
        logic signed [15:0] v;
        j = k[4:0];
        t = 6'd32 - {1'b0, j};
        if (j > 5'd16) j = t[4:0];
        case (j)
            5'd0:    v = 16'sd0;
            5'd1:    v = 16'sd3212;
            5'd2:    v = 16'sd6393;
            5'd3:    v = 16'sd9512;
            5'd4:    v = 16'sd12539;
            5'd5:    v = 16'sd15446;
            5'd6:    v = 16'sd18204;
            5'd7:    v = 16'sd20787;
            5'd8:    v = 16'sd23170;
            5'd9:    v = 16'sd25329;
            5'd10:   v = 16'sd27245;
            5'd11:   v = 16'sd28898;
            5'd12:   v = 16'sd30273;
            5'd13:   v = 16'sd31356;
            5'd14:   v = 16'sd32137;
            5'd15:   v = 16'sd32609;
            5'd16:   v = 16'sd32767;
            default: v = 16'sd0;
        endcase
        return k[5] ? -v : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            inc_r     <= '0;
            count     <= '0;
            n_r       <= '0;
            off_r     <= '0;
            drain_cnt <= '0;
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            x0        <= '0;
            idx0      <= '0;
            diff1     <= '0;
            d2        <= '0;
            sin1      <= '0;
            cos1      <= '0;
            pi2       <= '0;
            pq2       <= '0;
            res_valid <= 1'b0;
            i_acc     <= '0;
            q_acc     <= '0;
            dc_acc    <= '0;
        end else begin
            // Pipeline advances every cycle; the valid tags gate accumulation.
            v0    <= 1'b0;
            v1    <= v0;
            diff1 <= DW'($signed(x0)) - DW'($signed(off_r));
            sin1  <= lut(idx0);
            cos1  <= lut(idx0 + 6'd16);
            v2    <= v1;
            pi2   <= PW'(diff1) * PW'(sin1);
            pq2   <= PW'(diff1) * PW'(cos1);
            d2    <= diff1;
            if (v2) begin
                i_acc  <= i_acc + ACC_W'(pi2);
                q_acc  <= q_acc + ACC_W'(pq2);
                dc_acc <= dc_acc + ACC_W'(d2);
            end
            res_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        i_acc  <= '0;
                        q_acc  <= '0;
                        dc_acc <= '0;
                        phase  <= '0;
                        count  <= '0;
                        inc_r  <= phase_inc;
                        n_r    <= n_samples;
                        off_r  <= offset;
                        if (n_samples == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        v0    <= 1'b0;
                        v1    <= 1'b0;
                        v2    <= 1'b0;
                    end else if (accept) begin
                        v0    <= 1'b1;
                        x0    <= s_data;
                        idx0  <= phase[PHASE_W-1 -: 6];
                        phase <= phase + inc_r;
                        count <= count + 1'b1;
                        if (count + 1'b1 == n_r) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Final accumulate lands on the same edge that enters DONE.
                    if (abort) begin
                        state <= IDLE;
                        v0    <= 1'b0;
                        v1    <= 1'b0;
                        v2    <= 1'b0;
                    end else if (drain_cnt == 2'd2) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ac_lockin_detector.sv
// Self-checking bench for ac_lockin_detector: directed scenarios plus randomized runs
// compared against a floating-point correlation model.
module tb_ac_lockin_detector;
    logic        clk = 1'b0;
    logic        rst, start, abort, s_valid, s_ready, busy, res_valid;
    logic [15:0] phase_inc, n_samples, offset, s_data;
    logic [47:0] i_acc, q_acc, dc_acc;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int smp[$];

    always #5 clk = ~clk;

    ac_lockin_detector #(.DATA_W(16), .PHASE_W(16), .NSAMP_W(16), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .phase_inc(phase_inc), .n_samples(n_samples), .offset(offset),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy),
        .res_valid(res_valid), .i_acc(i_acc), .q_acc(q_acc), .dc_acc(dc_acc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int lutv(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic longint wrap48(input longint v);
        longint m;
        m = v & ((longint'(1) << 48) - 1);
        if (m >= (longint'(1) << 47)) m = m - (longint'(1) << 48);
        return m;
    endfunction

    // Reference: sum over the queued samples with phase stepping from 0.
    function automatic void model(input int inc, input int off,
                                  output longint ei, output longint eq, output longint ed);
        longint si, sq, sd;
        int ph, d, idx;
        si = 0; sq = 0; sd = 0; ph = 0;
        foreach (smp[k]) begin
            d   = smp[k] - off;
            idx = ph / 1024;
            si += longint'(d) * lutv(idx);
            sq += longint'(d) * lutv((idx + 16) % 64);
            sd += d;
            ph  = (ph + inc) % 65536;
        end
        ei = wrap48(si);
        eq = wrap48(sq);
        ed = wrap48(sd);
    endfunction

    // Runs one measurement from smp; lat is res_valid edge minus last accept edge (or start edge).
    task automatic do_run(input int inc, input int n, input int off, input int gap, input bit glitch,
                          output longint oi, output longint oq, output longint od,
                          output int pulses, output int lat, output int rdy, output bit held);
        int k, last, first;
        bit acc;
        k = 0; first = -1; pulses = 0; rdy = 0; held = 1'b1; oi = 0; oq = 0; od = 0; lat = -1;
        phase_inc = 16'(inc); n_samples = 16'(n); offset = 16'(off); start = 1'b1;
        tick();
        start = 1'b0;
        last  = cyc;
        if (res_valid) begin
            pulses++; first = cyc;
            oi = $signed(i_acc); oq = $signed(q_acc); od = $signed(dc_acc);
        end
        for (int c = 0; c < 3000; c++) begin
            if (first >= 0 && cyc >= first + 3) break;
            if (glitch && c == 1) begin
                start = 1'b1; n_samples = 16'd1; offset = 16'd77; phase_inc = 16'h1234;
            end else if (glitch && c == 2) begin
                start = 1'b0; phase_inc = 16'(inc); n_samples = 16'(n); offset = 16'(off);
            end
            if (k < n) begin
                s_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
                s_data  = 16'(smp[k]);
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready;
            if (s_ready) rdy++;
            tick();
            if (acc) begin
                k++;
                if (k == n) last = cyc;
            end
            if (res_valid) begin
                pulses++;
                if (first < 0) begin
                    first = cyc;
                    oi = $signed(i_acc); oq = $signed(q_acc); od = $signed(dc_acc);
                end
            end else if (first >= 0) begin
                if ($signed(i_acc) != oi || $signed(q_acc) != oq || $signed(dc_acc) != od) held = 1'b0;
            end
        end
        if (first >= 0) lat = first - last;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        phase_inc = '0; n_samples = '0; offset = '0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (i_acc !== 48'd0) begin errors++; $display("FAIL reset_i_acc: got %0d expected 0", i_acc); end
        checks++; if (q_acc !== 48'd0) begin errors++; $display("FAIL reset_q_acc: got %0d expected 0", q_acc); end
        checks++; if (dc_acc !== 48'd0) begin errors++; $display("FAIL reset_dc_acc: got %0d expected 0", dc_acc); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint oi, oq, od; int p, lat, rdy; bit held;
        smp = '{0, 100, 0, -100};
        do_run(32'h4000, 4, 0, 0, 1'b0, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 64'sd6553400) begin errors++; $display("FAIL basic_i: got %0d expected 6553400", oi); end
        checks++; if (oq != 0) begin errors++; $display("FAIL basic_q: got %0d expected 0", oq); end
        checks++; if (od != 0) begin errors++; $display("FAIL basic_dc: got %0d expected 0", od); end
        checks++; if (p != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", p); end
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_held: got %b expected 1", held); end
    endtask

    task automatic test_const();
        longint oi, oq, od; int p, lat, rdy; bit held;
        smp = {};
        for (int k = 0; k < 64; k++) smp.push_back(1000);
        do_run(32'h0400, 64, 0, 0, 1'b0, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 0) begin errors++; $display("FAIL const_i: got %0d expected 0", oi); end
        checks++; if (oq != 0) begin errors++; $display("FAIL const_q: got %0d expected 0", oq); end
        checks++; if (od != 64'sd64000) begin errors++; $display("FAIL const_dc: got %0d expected 64000", od); end
        checks++; if (p != 1) begin errors++; $display("FAIL const_pulses: got %0d expected 1", p); end
    endtask

    task automatic test_offset_gaps();
        longint oi, oq, od; int p, lat, rdy; bit held;
        smp = '{50, 150, 50, -50};
        do_run(32'h4000, 4, 50, 1, 1'b0, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 64'sd6553400) begin errors++; $display("FAIL offset_i: got %0d expected 6553400", oi); end
        checks++; if (oq != 0) begin errors++; $display("FAIL offset_q: got %0d expected 0", oq); end
        checks++; if (od != 0) begin errors++; $display("FAIL offset_dc: got %0d expected 0", od); end
        checks++; if (p != 1) begin errors++; $display("FAIL offset_pulses: got %0d expected 1", p); end
        checks++; if (lat != 3) begin errors++; $display("FAIL offset_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_zero_n();
        longint oi, oq, od; int p, lat, rdy; bit held;
        smp = {};
        do_run(32'h4000, 0, 0, 0, 1'b0, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 0 || oq != 0 || od != 0) begin
            errors++; $display("FAIL zero_n_accs: got i=%0d q=%0d dc=%0d expected all 0", oi, oq, od);
        end
        checks++; if (p != 1) begin errors++; $display("FAIL zero_n_pulses: got %0d expected 1", p); end
        // res_valid is high during the cycle right after the start edge.
        checks++; if (lat != 0) begin errors++; $display("FAIL zero_n_latency: got %0d expected 0", lat); end
        checks++; if (rdy != 0) begin errors++; $display("FAIL zero_n_s_ready: got %0d ready cycles expected 0", rdy); end
    endtask

    task automatic test_abort();
        longint oi, oq, od; int p, lat, rdy; bit held;
        int seen;
        phase_inc = 16'h4000; n_samples = 16'd4; offset = '0; start = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 16'd0;
        tick();
        s_data = 16'd100;
        tick();
        s_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_s_ready: got %b expected 0", s_ready); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result: got %0d pulses expected 0", seen); end
        smp = '{0, 100, 0, -100};
        do_run(32'h4000, 4, 0, 0, 1'b0, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 64'sd6553400) begin errors++; $display("FAIL abort_rerun_i: got %0d expected 6553400", oi); end
        checks++; if (od != 0) begin errors++; $display("FAIL abort_rerun_dc: got %0d expected 0", od); end
        checks++; if (p != 1) begin errors++; $display("FAIL abort_rerun_pulses: got %0d expected 1", p); end
    endtask

    task automatic test_rst_mid_run();
        longint ei, eq, ed;
        int seen;
        smp = '{0, 100};
        model(32'h4000, 0, ei, eq, ed);
        phase_inc = 16'h4000; n_samples = 16'd4; offset = '0; start = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b1; s_data = 16'd0;
        tick();
        s_data = 16'd100;
        tick();
        s_valid = 1'b0;
        repeat (4) tick();
        checks++; if ($signed(i_acc) != ei) begin errors++; $display("FAIL partial_i: got %0d expected %0d", $signed(i_acc), ei); end
        checks++; if ($signed(dc_acc) != ed) begin errors++; $display("FAIL partial_dc: got %0d expected %0d", $signed(dc_acc), ed); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL async_rst_ctrl: got busy=%b s_ready=%b expected 0 0", busy, s_ready);
        end
        checks++; if (i_acc !== 48'd0 || q_acc !== 48'd0 || dc_acc !== 48'd0) begin
            errors++; $display("FAIL async_rst_accs: got i=%0d q=%0d dc=%0d expected 0", i_acc, q_acc, dc_acc);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (res_valid || busy) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL post_rst_idle: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_start_while_busy();
        longint oi, oq, od; int p, lat, rdy; bit held;
        smp = '{0, 100, 0, -100};
        do_run(32'h4000, 4, 0, 1, 1'b1, oi, oq, od, p, lat, rdy, held);
        checks++; if (oi != 64'sd6553400) begin errors++; $display("FAIL busy_start_i: got %0d expected 6553400", oi); end
        checks++; if (oq != 0) begin errors++; $display("FAIL busy_start_q: got %0d expected 0", oq); end
        checks++; if (od != 0) begin errors++; $display("FAIL busy_start_dc: got %0d expected 0", od); end
        checks++; if (p != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", p); end
    endtask

    task automatic test_random();
        longint oi, oq, od, ei, eq, ed; int p, lat, rdy; bit held;
        int inc, n, off;
        for (int r = 0; r < 6; r++) begin
            inc = int'($urandom_range(0, 65535));
            n   = int'($urandom_range(1, 40));
            off = int'($urandom_range(0, 65535)) - 32768;
            smp = {};
            for (int k = 0; k < n; k++) smp.push_back(int'($urandom_range(0, 65535)) - 32768);
            model(inc, off, ei, eq, ed);
            do_run(inc, n, off, 2, 1'b0, oi, oq, od, p, lat, rdy, held);
            checks++; if (oi != ei) begin errors++; $display("FAIL rand%0d_i: got %0d expected %0d", r, oi, ei); end
            checks++; if (oq != eq) begin errors++; $display("FAIL rand%0d_q: got %0d expected %0d", r, oq, eq); end
            checks++; if (od != ed) begin errors++; $display("FAIL rand%0d_dc: got %0d expected %0d", r, od, ed); end
            checks++; if (p != 1) begin errors++; $display("FAIL rand%0d_pulses: got %0d expected 1", r, p); end
            checks++; if (lat != 3) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 3", r, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_const();
        test_offset_gaps();
        test_zero_n();
        test_abort();
        test_rst_mid_run();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
